// File: rtl/shift_sub_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock, start/finish handshake.
// Optional build macro DIV_EARLY_EXIT_EN: trivial ops (divisor==0 or dividend<divisor) skip the iteration.
module shift_sub_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             finish,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
`ifdef DIV_EARLY_EXIT_EN
  logic             early_q;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] dvd_d;

  // The trial remainder is one bit wider than the operands; the difference fits
  // in WIDTH bits whenever it is kept, since it is then smaller than the divisor.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - dsr_q;
    qbit  = (trial >= {1'b0, dsr_q});
    rem_d = qbit ? diff : trial[WIDTH-1:0];
    dvd_d = {dvd_q[WIDTH-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      early_q   <= 1'b0;
`endif
    end else begin
      finish <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q   <= dividend;
            dsr_q   <= divisor;
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state_q <= CALC;
`ifdef DIV_EARLY_EXIT_EN
            early_q <= (divisor == '0) || (dividend < divisor);
`endif
          end
        end
        CALC: begin
`ifdef DIV_EARLY_EXIT_EN
          // Early exit spends a single CALC cycle so finish lands in cycle 2.
          if (early_q) begin
            quotient  <= (dsr_q == '0) ? '1 : '0;
            remainder <= dvd_q;
            finish    <= 1'b1;
            busy      <= 1'b0;
            state_q   <= DONE;
          end else
`endif
          begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            if (cnt_q == '0) begin
              quotient  <= dvd_d;
              remainder <= rem_d;
              finish    <= 1'b1;
              busy      <= 1'b0;
              state_q   <= DONE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: table of divide vectors plus handshake corner sequences.
module tb_shift_sub_divider;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         finish;
  logic         busy;

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .finish    (finish),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int unsigned  c0;
    int unsigned  lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lat_for(input logic [W-1:0] dvd, input logic [W-1:0] dsr);
    return (EE && (dsr == '0 || dvd < dsr)) ? 2 : 17;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                       input logic [W-1:0] q, input logic [W-1:0] r, input bit push);
    exp_t e;
    start    = 1'b1;
    dividend = dvd;
    divisor  = dsr;
    if (push) begin
      e.q = q; e.r = r; e.c0 = cyc; e.lat = lat_for(dvd, dsr);
      sb.push_back(e);
    end
    step();
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    check("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (finish) begin
      if (sb.size() == 0) begin
        check("spurious_finish", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("latency", cyc - e.c0, e.lat);
      end
    end
  end

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2};
    vecs[1]  = '{16'hFFFF,  16'h0001,   16'hFFFF,   16'd0};
    vecs[2]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0};
    vecs[3]  = '{16'd3,     16'd10,     16'd0,      16'd3};
    vecs[4]  = '{16'd1234,  16'd0,      16'hFFFF,   16'd1234};
    vecs[5]  = '{16'd0,     16'd5,      16'd0,      16'd0};
    vecs[6]  = '{16'd48,    16'd18,     16'd2,      16'd12};
    vecs[7]  = '{16'd500,   16'd9,      16'd55,     16'd5};
    vecs[8]  = '{16'd40000, 16'd123,    16'd325,    16'd25};
    vecs[9]  = '{16'h8000,  16'h8001,   16'd0,      16'h8000};
    vecs[10] = '{16'd7,     16'd2,      16'd3,      16'd1};
    vecs[11] = '{16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    step(); step();
    rst = 1'b0;
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_finish", finish, 0);
    check("reset_busy", busy, 0);

    // Busy window and hold-after-finish for a normal op.
    check("busy_cycle0", busy, 0);
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      check($sformatf("busy_cycle%0d", k), busy, (k <= 16) ? 1 : 0);
      step();
    end
    wait_drain();
    repeat (5) step();
    check("hold_quotient", quotient, 14);
    check("hold_remainder", remainder, 2);

    foreach (vecs[i]) begin
      issue(vecs[i].dvd, vecs[i].dsr, vecs[i].q, vecs[i].r, 1'b1);
      wait_drain();
    end

    // A start pulsed mid-operation must be ignored.
    issue(16'd500, 16'd9, 16'd55, 16'd5, 1'b1);
    repeat (4) step();
    start = 1'b1; dividend = 16'd7; divisor = 16'd2;
    step();
    start = 1'b0;
    wait_drain();
    repeat (20) step();

    // Reset mid-CALC drops the op; no finish may follow.
    issue(16'd500, 16'd9, 16'd0, 16'd0, 1'b0);
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    issue(16'd48, 16'd18, 16'd2, 16'd12, 1'b1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
